// File: rtl/render_sequencer.sv
// render_sequencer: per-frame framebuffer clear and sprite command scheduler for sprite_render.
// Define SEQ_SPRITE_CULL_EN to discard commands whose origin lies outside the visible area.
module render_sequencer #(
  parameter int FB_DEPTH   = 307200,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 4,
  parameter int BG_INDEX   = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 6,
  parameter int COORD_W    = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic               cmd_last,
  output logic               spr_start,
  output logic [ID_W-1:0]    spr_id,
  output logic [COORD_W-1:0] spr_x,
  output logic [COORD_W-1:0] spr_y,
  input  logic               spr_done,
  input  logic [ADDR_W-1:0]  spr_wr_addr,
  input  logic [DATA_W-1:0]  spr_wr_data,
  input  logic               spr_wr_en,
  output logic [ADDR_W-1:0]  fb_wr_addr,
  output logic [DATA_W-1:0]  fb_wr_data,
  output logic               fb_wr_en,
  output logic               frame_done,
  output logic               frame_overrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ID_W + 2 * COORD_W + 1;
  typedef enum logic [1:0] {WAIT_VSYNC, CLEAR, ISSUE, BUSY} state_t;
  state_t state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [ADDR_W-1:0] clr_addr;
  logic vsync_d, run, pend, last, vs_fall, push, pop, cull;
  logic [ID_W-1:0] head_id;
  logic [COORD_W-1:0] head_x, head_y;
  logic head_last;
  assign vs_fall = vsync_d & ~vsync;
  assign cmd_ready = run & (count != (PW+1)'(FIFO_DEPTH));
  assign push = cmd_valid & cmd_ready;
  assign pop = (state == ISSUE) && !vs_fall && (count != '0);
  assign {head_id, head_x, head_y, head_last} = mem[rd_ptr];
`ifdef SEQ_SPRITE_CULL_EN
  assign cull = (head_x >= COORD_W'(H_RES)) || (head_y >= COORD_W'(V_RES));
`else
  assign cull = 1'b0;
`endif
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {cmd_id, cmd_x, cmd_y, cmd_last};
  // run holds cmd_ready low until the first clock after reset release
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state         <= WAIT_VSYNC;
      vsync_d       <= 1'b1;
      clr_addr      <= '0;
      pend          <= 1'b0;
      last          <= 1'b0;
      spr_start     <= 1'b0;
      spr_id        <= '0;
      spr_x         <= '0;
      spr_y         <= '0;
      fb_wr_addr    <= '0;
      fb_wr_data    <= '0;
      fb_wr_en      <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      vsync_d       <= vsync;
      spr_start     <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= vs_fall && (state != WAIT_VSYNC);
      fb_wr_en      <= 1'b0;
      case (state)
        WAIT_VSYNC: if (vs_fall) begin
          state    <= CLEAR;
          clr_addr <= '0;
        end
        CLEAR: begin
          fb_wr_en   <= 1'b1;
          fb_wr_addr <= clr_addr;
          fb_wr_data <= DATA_W'(BG_INDEX);
          if (vs_fall) clr_addr <= '0;
          else if (clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
            clr_addr <= '0;
            state    <= ISSUE;
          end else clr_addr <= clr_addr + ADDR_W'(1);
        end
        ISSUE: if (vs_fall) begin
          state    <= CLEAR;
          clr_addr <= '0;
        end else if (pop) begin
          if (cull) begin
            if (head_last) begin
              frame_done <= 1'b1;
              state      <= pend ? CLEAR : WAIT_VSYNC;
              clr_addr   <= '0;
              pend       <= 1'b0;
            end
          end else begin
            spr_start <= 1'b1;
            spr_id    <= head_id;
            spr_x     <= head_x;
            spr_y     <= head_y;
            last      <= head_last;
            state     <= BUSY;
          end
        end
        BUSY: begin
          fb_wr_en   <= spr_wr_en;
          fb_wr_addr <= spr_wr_addr;
          fb_wr_data <= spr_wr_data;
          // a done in the start cycle belongs to the previous sprite and is dropped
          if (spr_done && !spr_start) begin
            if (pend || vs_fall) begin
              state    <= CLEAR;
              clr_addr <= '0;
              pend     <= 1'b0;
            end else begin
              frame_done <= last;
              state      <= last ? WAIT_VSYNC : ISSUE;
            end
          end else if (vs_fall) pend <= 1'b1;
        end
        default: state <= WAIT_VSYNC;
      endcase
    end
endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: directed checks of clear timing, command flow, FIFO full, overrun and reset.
module tb_render_sequencer;
  logic clock = 1'b0, reset_n = 1'b0, vsync = 1'b1;
  logic cmd_valid = 1'b0, cmd_last = 1'b0, spr_done = 1'b0, spr_wr_en = 1'b0;
  logic [5:0] cmd_id = '0;
  logic [9:0] cmd_x = '0, cmd_y = '0;
  logic [18:0] spr_wr_addr = '0;
  logic [3:0] spr_wr_data = '0;
  logic cmd_ready, spr_start, fb_wr_en, frame_done, frame_overrun;
  logic [5:0] spr_id;
  logic [9:0] spr_x, spr_y;
  logic [18:0] fb_wr_addr;
  logic [3:0] fb_wr_data;
  int total = 0, passed = 0;
  always #5 clock = ~clock;
  render_sequencer #(.FB_DEPTH(16), .BG_INDEX(5)) dut (
    .clock(clock), .reset_n(reset_n), .vsync(vsync),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_last(cmd_last),
    .spr_start(spr_start), .spr_id(spr_id), .spr_x(spr_x), .spr_y(spr_y), .spr_done(spr_done),
    .spr_wr_addr(spr_wr_addr), .spr_wr_data(spr_wr_data), .spr_wr_en(spr_wr_en),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_wr_en(fb_wr_en),
    .frame_done(frame_done), .frame_overrun(frame_overrun)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic push(input logic [5:0] id, input logic [9:0] x, input logic [9:0] y, input logic lst);
    cmd_valid = 1'b1;
    cmd_id = id;
    cmd_x = x;
    cmd_y = y;
    cmd_last = lst;
    step();
    cmd_valid = 1'b0;
  endtask
  // called just after the edge that raised spr_start; done is answered 4 cycles later
  task automatic do_sprite(input logic [5:0] id, input logic [9:0] x, input logic [9:0] y, input logic lst);
    chk("start", 32'(spr_start), 1);
    chk("spr_id", 32'(spr_id), 32'(id));
    chk("spr_x", 32'(spr_x), 32'(x));
    chk("spr_y", 32'(spr_y), 32'(y));
    spr_wr_en = 1'b1;
    spr_wr_addr = 19'(id) + 19'd100;
    spr_wr_data = id[3:0];
    spr_done = 1'b1;
    step();
    spr_wr_en = 1'b0;
    spr_done = 1'b0;
    chk("echo_en", 32'(fb_wr_en), 1);
    chk("echo_addr", 32'(fb_wr_addr), 32'(id) + 32'd100);
    chk("echo_data", 32'(fb_wr_data), 32'(id[3:0]));
    chk("start_pulse", 32'(spr_start), 0);
    chk("early_done_fd", 32'(frame_done), 0);
    step();
    chk("echo_off", 32'(fb_wr_en), 0);
    chk("early_done_busy", 32'(spr_start), 0);
    chk("id_hold", 32'(spr_id), 32'(id));
    chk("x_hold", 32'(spr_x), 32'(x));
    step();
    spr_done = 1'b1;
    step();
    spr_done = 0;
    chk("frame_done", 32'(frame_done), 32'(lst));
    chk("y_hold", 32'(spr_y), 32'(y));
  endtask
  initial begin
    #3;
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_fb_en", 32'(fb_wr_en), 0);
    chk("rst_fb_addr", 32'(fb_wr_addr), 0);
    chk("rst_start", 32'(spr_start), 0);
    chk("rst_id", 32'(spr_id), 0);
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_ovr", 32'(frame_overrun), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 1);
    chk("idle_no_wr", 32'(fb_wr_en), 0);
    push(6'd1, 10'd10, 10'd20, 1'b0);
    push(6'd2, 10'd30, 10'd40, 1'b0);
    push(6'd3, 10'd50, 10'd60, 1'b1);
    chk("wait_no_wr", 32'(fb_wr_en), 0);
    chk("wait_no_start", 32'(spr_start), 0);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    chk("clr_latency", 32'(fb_wr_en), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("clr_en", 32'(fb_wr_en), 1);
      chk("clr_addr", 32'(fb_wr_addr), 32'(i));
      chk("clr_data", 32'(fb_wr_data), 5);
    end
    step();
    chk("clr_end", 32'(fb_wr_en), 0);
    do_sprite(6'd1, 10'd10, 10'd20, 1'b0);
    step();
    do_sprite(6'd2, 10'd30, 10'd40, 1'b0);
    step();
    do_sprite(6'd3, 10'd50, 10'd60, 1'b1);
    step();
    chk("fd_once", 32'(frame_done), 0);
    chk("idle_start", 32'(spr_start), 0);
    for (int i = 0; i < 16; i++) begin
      push(6'(10 + i), 10'(i), 10'(i), i == 0);
      chk("ready_fill", 32'(cmd_ready), 32'(i != 15));
    end
    push(6'd63, 10'd1, 10'd1, 1'b0);
    chk("ready_full", 32'(cmd_ready), 0);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("ovr_pre_addr", 32'(fb_wr_addr), 32'(i));
    end
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    chk("ovr_clear", 32'(frame_overrun), 1);
    step();
    chk("ovr_pulse", 32'(frame_overrun), 0);
    chk("restart_en", 32'(fb_wr_en), 1);
    chk("restart_addr", 32'(fb_wr_addr), 0);
    repeat (15) step();
    chk("restart_end", 32'(fb_wr_addr), 15);
    step();
    chk("pop_start", 32'(spr_start), 1);
    chk("pop_id", 32'(spr_id), 10);
    chk("ready_after_pop", 32'(cmd_ready), 1);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    chk("ovr_busy", 32'(frame_overrun), 1);
    step();
    chk("ovr_busy_pulse", 32'(frame_overrun), 0);
    step();
    spr_done = 1'b1;
    step();
    spr_done = 1'b0;
    chk("no_fd_pend", 32'(frame_done), 0);
    step();
    chk("pend_clr_en", 32'(fb_wr_en), 1);
    chk("pend_clr_addr", 32'(fb_wr_addr), 0);
    chk("pend_clr_data", 32'(fb_wr_data), 5);
    repeat (15) step();
    step();
    chk("fifo_kept_start", 32'(spr_start), 1);
    chk("fifo_kept_id", 32'(spr_id), 11);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(cmd_ready), 0);
    chk("midrst_start", 32'(spr_start), 0);
    chk("midrst_id", 32'(spr_id), 0);
    step();
    reset_n = 1'b1;
    step();
    chk("midrst_ready_back", 32'(cmd_ready), 1);
    chk("midrst_no_wr", 32'(fb_wr_en), 0);
`ifdef SEQ_SPRITE_CULL_EN
    push(6'd5, 10'd700, 10'd10, 1'b1);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    repeat (16) step();
    step();
    chk("cull_fd", 32'(frame_done), 1);
    chk("cull_no_start", 32'(spr_start), 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
